// File: rtl/conv1d_cfu_sequencer.sv
// Autonomous command sequencer for the conv1d CFU: loads the job into the CFU,
// starts it, and streams the packed int8 results into the destination memory.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; NOP command driven
// ST_INIT  | CFU init command (funct7 0)
// ST_SIZE  | job length command (funct7 4)
// ST_BIAS  | bias command (funct7 8)
// ST_KERN0 | kernel taps 0-3 (funct7 2, inputs_0 = 0)
// ST_KERN1 | kernel taps 4-7 (funct7 2, inputs_0 = 1)
// ST_FETCH | read source word k; no command
// ST_ISSUE | load input word k (funct7 1)
// ST_START | start compute (funct7 5)
// ST_READ  | readback k = 0..W, response k>0 written to dst word k-1
// ST_DONE  | one-cycle done (and err if the job was rejected)
module conv1d_cfu_sequencer #(
    parameter int         MAX_LEN    = 1024,
    parameter int         AW         = 8,
    parameter logic [6:0] NOP_FUNCT7 = 7'd9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   len,
    input  logic [31:0]   bias,
    input  logic [31:0]   kern_w0,
    input  logic [31:0]   kern_w1,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          src_en,
    output logic [AW-1:0] src_addr,
    input  logic [31:0]   src_data,
    output logic          dst_we,
    output logic [AW-1:0] dst_addr,
    output logic [31:0]   dst_data,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [9:0]    cmd_function_id,
    output logic [31:0]   cmd_inputs_0,
    output logic [31:0]   cmd_inputs_1,
    input  logic          rsp_valid,
    output logic          rsp_ready,
    input  logic [31:0]   rsp_outputs_0
);
    localparam int KW = AW + 1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_INIT, ST_SIZE, ST_BIAS, ST_KERN0, ST_KERN1,
        ST_FETCH, ST_ISSUE, ST_START, ST_READ, ST_DONE
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   len_q, bias_q, kern0_q, kern1_q, src_q;
    logic [KW-1:0] k_q, w_q, w_last, k_prev, rd_idx;
    logic          err_q, fetched_q, len_ok;
    logic [6:0]    funct7;
    logic          unused_cmd_ready;

    // Commands advance on the response alone; cmd_ready carries no extra information.
    assign unused_cmd_ready = cmd_ready;

    assign len_ok  = (len != 32'd0) && (len[2:0] == 3'd0) && (len <= 32'(MAX_LEN));
    assign w_last  = w_q - 1'b1;
    assign k_prev  = k_q - 1'b1;
    assign rd_idx  = (k_q > w_last) ? w_last : k_q;
    assign cmd_function_id = {funct7, 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            bias_q    <= '0;
            kern0_q   <= '0;
            kern1_q   <= '0;
            src_q     <= '0;
            k_q       <= '0;
            w_q       <= '0;
            err_q     <= 1'b0;
            fetched_q <= 1'b0;
        end else begin
            state     <= state_nx;
            fetched_q <= (state == ST_FETCH);
            if (fetched_q) src_q <= src_data;
            case (state)
                ST_IDLE: if (start) begin
                    len_q   <= len;
                    bias_q  <= bias;
                    kern0_q <= kern_w0;
                    kern1_q <= kern_w1;
                    w_q     <= len[AW+2:2];
                    err_q   <= !len_ok;
                    k_q     <= '0;
                end
                ST_ISSUE: if (rsp_valid) k_q <= (k_q == w_last) ? '0 : k_q + 1'b1;
                ST_READ:  if (rsp_valid) k_q <= k_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = len_ok ? ST_INIT : ST_DONE;
            ST_INIT:  if (rsp_valid) state_nx = ST_SIZE;
            ST_SIZE:  if (rsp_valid) state_nx = ST_BIAS;
            ST_BIAS:  if (rsp_valid) state_nx = ST_KERN0;
            ST_KERN0: if (rsp_valid) state_nx = ST_KERN1;
            ST_KERN1: if (rsp_valid) state_nx = ST_FETCH;
            ST_FETCH: state_nx = ST_ISSUE;
            ST_ISSUE: if (rsp_valid) state_nx = (k_q == w_last) ? ST_START : ST_FETCH;
            ST_START: if (rsp_valid) state_nx = ST_READ;
            ST_READ:  if (rsp_valid && (k_q == w_q)) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        src_en       = 1'b0;
        src_addr     = '0;
        dst_we       = 1'b0;
        dst_addr     = '0;
        dst_data     = '0;
        cmd_valid    = 1'b0;
        rsp_ready    = 1'b0;
        funct7       = NOP_FUNCT7;
        cmd_inputs_0 = '0;
        cmd_inputs_1 = '0;
        case (state)
            ST_IDLE: ;
            ST_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            ST_FETCH: begin
                busy     = 1'b1;
                src_en   = 1'b1;
                src_addr = k_q[AW-1:0];
            end
            default: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                rsp_ready = 1'b1;
                case (state)
                    ST_INIT: funct7 = 7'd0;
                    ST_SIZE: begin
                        funct7       = 7'd4;
                        cmd_inputs_0 = len_q;
                    end
                    ST_BIAS: begin
                        funct7       = 7'd8;
                        cmd_inputs_0 = bias_q;
                    end
                    ST_KERN0: begin
                        funct7       = 7'd2;
                        cmd_inputs_1 = kern0_q;
                    end
                    ST_KERN1: begin
                        funct7       = 7'd2;
                        cmd_inputs_0 = 32'd1;
                        cmd_inputs_1 = kern1_q;
                    end
                    ST_ISSUE: begin
                        // First issue cycle uses the memory output directly; later cycles hold the copy.
                        funct7       = 7'd1;
                        cmd_inputs_0 = 32'(k_q);
                        cmd_inputs_1 = fetched_q ? src_data : src_q;
                    end
                    ST_START: funct7 = 7'd5;
                    ST_READ: begin
                        funct7       = 7'd3;
                        cmd_inputs_0 = 32'(rd_idx);
                        if (rsp_valid && (k_q != '0)) begin
                            dst_we   = 1'b1;
                            dst_addr = k_prev[AW-1:0];
                            dst_data = rsp_outputs_0;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end
endmodule
